regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/wb_rr_picker.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default sizing of the writeback path and the requester
// index enumeration used by the top module and the round-robin picker.
package regfile_wb_arbiter_pkg;

  localparam int NUM_REQ  = 3;   // writeback requesters
  localparam int ADDR_W   = 4;   // register address width
  localparam int DATA_W   = 32;  // register data width
  localparam int NUM_REGS = 16;  // registers tracked by the scoreboard

  // Requester slot assignment on the writeback bus.
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_MEM = 2'd1,
    REQ_MUL = 2'd2
  } req_idx_e;

endpackage

// File: rtl/wb_rr_picker.sv
// Two-winner round-robin picker for the writeback ports.
// Candidates are scanned ptr_i, ptr_i+1, ... (mod NUM_REQ). The first valid
// candidate wins port 1; the next valid candidate whose destination differs
// from the port-1 winner wins port 2. A candidate aimed at the same register
// as the port-1 winner is skipped so both ports never hit one register.
// Purely combinational; the data path is not an input, so the grant cannot
// depend on write data.
//
// Ports:
//   valid_i    - per-requester request valid
//   rd_i       - packed per-requester destination register
//   ptr_i      - round-robin start index
//   grant_o    - one-hot-or-two-hot grant vector
//   p1_valid_o / p1_idx_o - port-1 winner
//   p2_valid_o / p2_idx_o - port-2 winner
//   next_ptr_o - (last granted index + 1) mod NUM_REQ, or ptr_i when idle
import regfile_wb_arbiter_pkg::*;

module wb_rr_picker #(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_i,
  input  logic [IDX_W-1:0]          ptr_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      p1_valid_o,
  output logic [IDX_W-1:0]          p1_idx_o,
  output logic                      p2_valid_o,
  output logic [IDX_W-1:0]          p2_idx_o,
  output logic [IDX_W-1:0]          next_ptr_o
);

  logic [ADDR_W-1:0] p1_rd;
  int                cand;
  int                cand_nxt;

  always_comb begin
    grant_o    = '0;
    p1_valid_o = 1'b0;
    p1_idx_o   = '0;
    p2_valid_o = 1'b0;
    p2_idx_o   = '0;
    next_ptr_o = ptr_i;
    p1_rd      = '0;
    cand       = 0;
    cand_nxt   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_nxt = (cand + 1 >= NUM_REQ) ? 0 : cand + 1;
      if (valid_i[cand]) begin
        if (!p1_valid_o) begin
          p1_valid_o    = 1'b1;
          p1_idx_o      = IDX_W'(cand);
          p1_rd         = rd_i[cand*ADDR_W +: ADDR_W];
          grant_o[cand] = 1'b1;
          next_ptr_o    = IDX_W'(cand_nxt);
        end else if (!p2_valid_o && (rd_i[cand*ADDR_W +: ADDR_W] != p1_rd)) begin
          p2_valid_o    = 1'b1;
          p2_idx_o      = IDX_W'(cand);
          grant_o[cand] = 1'b1;
          next_ptr_o    = IDX_W'(cand_nxt);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of a two-write-port register file, plus a
// pending-write scoreboard.
//
// Handshake: a requester holds req_valid/req_rd/req_data until it sees
// req_ready; a transfer happens in the cycle where both are high. req_ready
// is combinational from req_valid, req_rd and the round-robin pointer.
// A grant in cycle N appears on RWx/Bus_Wx/RegWritex in cycle N+1; the
// register file writes on the edge that ends N+1.
//
// Ports:
//   clk, rst              - clock, async active-high reset
//   req_valid/rd/data     - per-requester writeback request
//   req_ready             - per-requester grant
//   alloc_valid/alloc_rd  - issue stage marks a register pending
//   busy_vec              - pending-write scoreboard
//   RW1/RW2, RegWrite1/2, Bus_W1/2 - registered register-file write ports
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W  = regfile_wb_arbiter_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      alloc_valid,
  input  logic [ADDR_W-1:0]         alloc_rd,
  output logic [NUM_REGS-1:0]       busy_vec,
  output logic [ADDR_W-1:0]         RW1,
  output logic [ADDR_W-1:0]         RW2,
  output logic                      RegWrite1,
  output logic                      RegWrite2,
  output logic [DATA_W-1:0]         Bus_W1,
  output logic [DATA_W-1:0]         Bus_W2
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant;
  logic                p1_valid, p2_valid;
  logic [IDX_W-1:0]    p1_idx, p2_idx, next_ptr;

  logic                we1_q, we1_d, we2_q, we2_d;
  logic [ADDR_W-1:0]   rw1_q, rw1_d, rw2_q, rw2_d;
  logic [DATA_W-1:0]   bw1_q, bw1_d, bw2_q, bw2_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  wb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i    (req_valid),
    .rd_i       (req_rd),
    .ptr_i      (rr_ptr_q),
    .grant_o    (grant),
    .p1_valid_o (p1_valid),
    .p1_idx_o   (p1_idx),
    .p2_valid_o (p2_valid),
    .p2_idx_o   (p2_idx),
    .next_ptr_o (next_ptr)
  );

  // No grants while reset is held, so no requester believes it transferred.
  assign req_ready = rst ? '0 : grant;

  always_comb begin
    rr_ptr_d = next_ptr;
    we1_d    = p1_valid;
    we2_d    = p2_valid;
    // Idle ports keep their last address/data; only the enable drops.
    rw1_d    = p1_valid ? req_rd[int'(p1_idx)*ADDR_W +: ADDR_W]   : rw1_q;
    bw1_d    = p1_valid ? req_data[int'(p1_idx)*DATA_W +: DATA_W] : bw1_q;
    rw2_d    = p2_valid ? req_rd[int'(p2_idx)*ADDR_W +: ADDR_W]   : rw2_q;
    bw2_d    = p2_valid ? req_data[int'(p2_idx)*DATA_W +: DATA_W] : bw2_q;

    // Clears are applied first so a same-edge allocation wins.
    busy_d = busy_q;
    if (we1_q) busy_d[rw1_q] = 1'b0;
    if (we2_q) busy_d[rw2_q] = 1'b0;
    if (alloc_valid) busy_d[alloc_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
      rw1_q    <= '0;
      rw2_q    <= '0;
      bw1_q    <= '0;
      bw2_q    <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we1_q    <= we1_d;
      we2_q    <= we2_d;
      rw1_q    <= rw1_d;
      rw2_q    <= rw2_d;
      bw1_q    <= bw1_d;
      bw2_q    <= bw2_d;
      busy_q   <= busy_d;
    end
  end

  assign RegWrite1 = we1_q;
  assign RegWrite2 = we2_q;
  assign RW1       = rw1_q;
  assign RW2       = rw2_q;
  assign Bus_W1    = bw1_q;
  assign Bus_W2    = bw2_q;
  assign busy_vec  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        alloc_valid;
  logic [3:0]  alloc_rd;
  logic [15:0] busy_vec;
  logic [3:0]  RW1, RW2;
  logic        RegWrite1, RegWrite2;
  logic [31:0] Bus_W1, Bus_W2;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [16];

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .busy_vec    (busy_vec),
    .RW1         (RW1),
    .RW2         (RW2),
    .RegWrite1   (RegWrite1),
    .RegWrite2   (RegWrite2),
    .Bus_W1      (Bus_W1),
    .Bus_W2      (Bus_W2)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register-file model fed by the write ports
  initial for (int i = 0; i < 16; i++) rf[i] = '0;
  always @(posedge clk) begin
    if (RegWrite1) rf[RW1] <= Bus_W1;
    if (RegWrite2) rf[RW2] <= Bus_W2;
  end

  typedef struct {
    logic [2:0]  valid;
    logic [11:0] rd;      // {rd2, rd1, rd0}
    logic [95:0] data;    // {d2, d1, d0}
    logic [2:0]  ready;
    logic        we1;
    logic [3:0]  rw1;
    logic [31:0] bw1;
    logic        we2;
    logic [3:0]  rw2;
    logic [31:0] bw2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] valid, input logic [3:0] r2, input logic [3:0] r1,
                              input logic [3:0] r0, input logic [31:0] d2, input logic [31:0] d1,
                              input logic [31:0] d0, input logic [2:0] ready,
                              input logic we1, input logic [3:0] rw1, input logic [31:0] bw1,
                              input logic we2, input logic [3:0] rw2, input logic [31:0] bw2);
    vec_t v;
    v.valid = valid; v.rd = {r2, r1, r0}; v.data = {d2, d1, d0}; v.ready = ready;
    v.we1 = we1; v.rw1 = rw1; v.bw1 = bw1; v.we2 = we2; v.rw2 = rw2; v.bw2 = bw2;
    return v;
  endfunction

  // driver: present one vector, check ready in-cycle, check write ports after the edge
  task automatic apply_vec(input vec_t v, input int i);
    @(negedge clk);
    req_valid = v.valid;
    req_rd    = v.rd;
    req_data  = v.data;
    #1;
    check($sformatf("v%0d ready", i), 64'(req_ready), 64'(v.ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d we1", i), 64'(RegWrite1), 64'(v.we1));
    check($sformatf("v%0d rw1", i), 64'(RW1), 64'(v.rw1));
    check($sformatf("v%0d bw1", i), 64'(Bus_W1), 64'(v.bw1));
    check($sformatf("v%0d we2", i), 64'(RegWrite2), 64'(v.we2));
    check($sformatf("v%0d rw2", i), 64'(RW2), 64'(v.rw2));
    check($sformatf("v%0d bw2", i), 64'(Bus_W2), 64'(v.bw2));
    check($sformatf("v%0d busy", i), 64'(busy_vec), 64'h0);
  endtask

  initial begin
    // pointer walk: 0 ->1 ->2 ->0 ->2 ->1 ->0 ->0 ->2 ->0 ->0
    vecs[0] = mk(3'b001, 4'd0, 4'd0, 4'd1, 32'h0, 32'h0, 32'hAAAAAAAA, 3'b001,
                 1, 4'd1, 32'hAAAAAAAA, 0, 4'd0, 32'h0);
    vecs[1] = mk(3'b010, 4'd0, 4'd6, 4'd0, 32'h0, 32'h11111111, 32'h0, 3'b010,
                 1, 4'd6, 32'h11111111, 0, 4'd0, 32'h0);
    vecs[2] = mk(3'b100, 4'd0, 4'd0, 4'd0, 32'h22222222, 32'h0, 32'h0, 3'b100,
                 1, 4'd0, 32'h22222222, 0, 4'd0, 32'h0);
    vecs[3] = mk(3'b111, 4'd5, 4'd4, 4'd3, 32'h50000005, 32'h40000004, 32'h30000003, 3'b011,
                 1, 4'd3, 32'h30000003, 1, 4'd4, 32'h40000004);
    vecs[4] = mk(3'b101, 4'd5, 4'd0, 4'd10, 32'h50000005, 32'h0, 32'h0A0A0A0A, 3'b101,
                 1, 4'd5, 32'h50000005, 1, 4'd10, 32'h0A0A0A0A);
    vecs[5] = mk(3'b100, 4'd12, 4'd0, 4'd0, 32'hC0C0C0C0, 32'h0, 32'h0, 3'b100,
                 1, 4'd12, 32'hC0C0C0C0, 0, 4'd10, 32'h0A0A0A0A);
    vecs[6] = mk(3'b111, 4'd8, 4'd7, 4'd7, 32'h88888888, 32'h71111111, 32'h70000000, 3'b101,
                 1, 4'd7, 32'h70000000, 1, 4'd8, 32'h88888888);
    vecs[7] = mk(3'b010, 4'd0, 4'd7, 4'd0, 32'h0, 32'h71111111, 32'h0, 3'b010,
                 1, 4'd7, 32'h71111111, 0, 4'd8, 32'h88888888);
    vecs[8] = mk(3'b111, 4'd13, 4'd13, 4'd13, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0, 3'b100,
                 1, 4'd13, 32'hD2D2D2D2, 0, 4'd8, 32'h88888888);
    vecs[9] = mk(3'b000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0, 3'b000,
                 0, 4'd13, 32'hD2D2D2D2, 0, 4'd8, 32'h88888888);

    // reset state, with requests present
    rst = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    req_valid = 3'b111; req_rd = {4'd3, 4'd2, 4'd1}; req_data = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 64'(req_ready), 64'h0);
    check("rst we1", 64'(RegWrite1), 64'h0);
    check("rst we2", 64'(RegWrite2), 64'h0);
    check("rst rw1", 64'(RW1), 64'h0);
    check("rst bw2", 64'(Bus_W2), 64'h0);
    check("rst busy", 64'(busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    check("rf7 last", 64'(rf[7]), 64'h71111111);
    check("rf0 written", 64'(rf[0]), 64'h22222222);

    // idle for 10 cycles
    @(negedge clk);
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle%0d we1", i), 64'(RegWrite1), 64'h0);
      check($sformatf("idle%0d we2", i), 64'(RegWrite2), 64'h0);
    end
    check("idle rr_ptr", 64'(dut.rr_ptr_q), 64'h0);

    // scoreboard: set, then cleared two cycles after the grant
    @(negedge clk);
    alloc_valid = 1'b1; alloc_rd = 4'd9;
    @(posedge clk); #1;
    check("sb alloc", 64'(busy_vec), 64'h0200);
    @(negedge clk);
    alloc_valid = 1'b0;
    req_valid = 3'b001; req_rd = {4'd0, 4'd0, 4'd9}; req_data = {64'h0, 32'h99999999};
    #1;
    check("sb ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    check("sb we1", 64'(RegWrite1), 64'h1);
    check("sb busy N+1", 64'(busy_vec[9]), 64'h1);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    check("sb busy N+2", 64'(busy_vec[9]), 64'h0);
    check("sb rf9", 64'(rf[9]), 64'h99999999);

    // scoreboard: alloc and clear of the same register on one edge
    @(negedge clk);
    alloc_valid = 1'b1; alloc_rd = 4'd9;
    req_valid = 3'b001; req_data = {64'h0, 32'h12345678};
    @(posedge clk); #1;
    check("sb2 busy set", 64'(busy_vec[9]), 64'h1);
    check("sb2 we1", 64'(RegWrite1), 64'h1);
    @(negedge clk);
    req_valid = '0;   // alloc_valid stays high on rd 9 for the clearing edge
    @(posedge clk); #1;
    check("sb2 set wins", 64'(busy_vec[9]), 64'h1);
    check("sb2 we1 low", 64'(RegWrite1), 64'h0);
    @(posedge clk); #1;   // re-alloc of an already-busy register
    check("sb2 realloc", 64'(busy_vec), 64'h0200);
    @(negedge clk);
    alloc_valid = 1'b0;

    // reset mid-flight
    @(negedge clk);
    req_valid = 3'b010; req_rd = {4'd0, 4'd2, 4'd0}; req_data = {32'h0, 32'hDEADBEEF, 32'h0};
    alloc_valid = 1'b1; alloc_rd = 4'd14;
    #1;
    check("mid ready", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    check("mid we1", 64'(RegWrite1), 64'h1);
    check("mid rw1", 64'(RW1), 64'h2);
    check("mid busy", 64'(busy_vec), 64'h4200);
    #2;
    alloc_valid = 1'b0; req_valid = 3'b111;
    rst = 1'b1;
    #1;
    check("mid rst we1", 64'(RegWrite1), 64'h0);
    check("mid rst rw1", 64'(RW1), 64'h0);
    check("mid rst bw1", 64'(Bus_W1), 64'h0);
    check("mid rst busy", 64'(busy_vec), 64'h0);
    check("mid rst ready", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    check("mid rf2 kept", 64'(rf[2]), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    req_rd = {4'd3, 4'd2, 4'd1};
    req_data = {32'h33333333, 32'h22220000, 32'h11110000};
    #1;
    check("post ready", 64'(req_ready), 64'h3);
    @(posedge clk); #1;
    check("post rw1", 64'(RW1), 64'h1);
    check("post bw1", 64'(Bus_W1), 64'h11110000);
    check("post rw2", 64'(RW2), 64'h2);
    check("post bw2", 64'(Bus_W2), 64'h22220000);
    @(negedge clk);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
